// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and the 7-segment digit encoding
// for the TM1638 frame builder.
package tm1638_pkg;

    // TM1638 command bytes
    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;  // write data, auto-increment address
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;  // set address 0
    localparam logic [7:0] CMD_DISP_ON   = 8'h88;  // display on, OR in brightness

    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] LED_ON    = 8'h01;
    localparam logic [7:0] BYTE_ZERO = 8'h00;
    localparam logic [3:0] IDX_LAST  = 4'd15;

    // Lamp state encoding from counter_for_traffic
    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;
    localparam logic [1:0] LAMP_OFF    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD_DATA = 3'd1,
        S_CMD_ADDR = 3'd2,
        S_DATA     = 3'd3,
        S_CMD_DISP = 3'd4
    } state_t;

    // Frozen copy of everything that goes on the display
    typedef struct packed {
        logic [3:0] chuc1;
        logic [3:0] dv1;
        logic [3:0] chuc2;
        logic [3:0] dv2;
        logic [1:0] light1;
        logic [1:0] light2;
    } snapshot_t;

    // BCD to gfedcba segment code; non-decimal values show a dash
    function automatic logic [7:0] seg7_code(input logic [3:0] bcd);
        logic [7:0] code;
        case (bcd)
            4'd0:    code = 8'h3F;
            4'd1:    code = 8'h06;
            4'd2:    code = 8'h5B;
            4'd3:    code = 8'h4F;
            4'd4:    code = 8'h66;
            4'd5:    code = 8'h6D;
            4'd6:    code = 8'h7D;
            4'd7:    code = 8'h07;
            4'd8:    code = 8'h7F;
            4'd9:    code = 8'h6F;
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment code encoder.
module bcd_to_seg7
    import tm1638_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    // Pure table lookup
    always_comb begin
        seg_o = seg7_code(bcd_i);
    end

endmodule

// File: rtl/tm1638_frame_builder.sv
// Builds complete TM1638 display frames (3 transactions, 19 bytes) from a
// snapshot of the traffic-light digits and lamps, streamed over valid/ready.
module tm1638_frame_builder
    import tm1638_pkg::*;
#(
    parameter logic [2:0] BRIGHTNESS     = 3'd7,
    parameter int         REFRESH_CYCLES = 1_000_000
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic [3:0] light_chuc1,
    input  logic [3:0] light_dv1,
    input  logic [3:0] light_chuc2,
    input  logic [3:0] light_dv2,
    input  logic [1:0] light1,
    input  logic [1:0] light2,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_last,
    input  logic       byte_ready,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    snapshot_t  snap_q, snap_d, live_s;
    logic       pending_q, pending_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_valid_q, byte_valid_d;
    logic       byte_last_q, byte_last_d;
    logic       busy_q, busy_d;
    logic       tick_s, xfer_s, frame_start_s, change_s;
    logic [7:0] seg_chuc1_s, seg_dv1_s, seg_chuc2_s, seg_dv2_s;
    logic [7:0] ram_byte_s;

    assign live_s   = '{chuc1: light_chuc1, dv1: light_dv1, chuc2: light_chuc2,
                        dv2: light_dv2, light1: light1, light2: light2};
    assign change_s = (live_s != snap_q);
    assign xfer_s   = byte_valid_q && byte_ready;

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_last  = byte_last_q;
    assign busy       = busy_q;

    // Digit encoders always look at the frozen snapshot, so a frame never tears
    bcd_to_seg7 u_seg_chuc1 (.bcd_i(snap_q.chuc1), .seg_o(seg_chuc1_s));
    bcd_to_seg7 u_seg_dv1   (.bcd_i(snap_q.dv1),   .seg_o(seg_dv1_s));
    bcd_to_seg7 u_seg_chuc2 (.bcd_i(snap_q.chuc2), .seg_o(seg_chuc2_s));
    bcd_to_seg7 u_seg_dv2   (.bcd_i(snap_q.dv2),   .seg_o(seg_dv2_s));

    // Periodic refresh tick; absent entirely when REFRESH_CYCLES is 0
    if (REFRESH_CYCLES > 0) begin : g_refresh
        localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
        logic [CNT_W-1:0] cnt_q;

        // Free-running counter wrapping at REFRESH_CYCLES-1
        always_ff @(posedge clk_50M) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign tick_s = (cnt_q == CNT_LAST);
    end else begin : g_no_refresh
        assign tick_s = 1'b0;
    end

    // Display RAM contents for a given address: digits on even, LEDs on odd
    always_comb begin
        ram_byte_s = BYTE_ZERO;
        case (idx_d)
            4'd0:    ram_byte_s = seg_chuc1_s;
            4'd1:    ram_byte_s = (snap_q.light1 == LAMP_RED)    ? LED_ON : BYTE_ZERO;
            4'd2:    ram_byte_s = seg_dv1_s;
            4'd3:    ram_byte_s = (snap_q.light1 == LAMP_YELLOW) ? LED_ON : BYTE_ZERO;
            4'd5:    ram_byte_s = (snap_q.light1 == LAMP_GREEN)  ? LED_ON : BYTE_ZERO;
            4'd11:   ram_byte_s = (snap_q.light2 == LAMP_RED)    ? LED_ON : BYTE_ZERO;
            4'd12:   ram_byte_s = seg_chuc2_s;
            4'd13:   ram_byte_s = (snap_q.light2 == LAMP_YELLOW) ? LED_ON : BYTE_ZERO;
            4'd14:   ram_byte_s = seg_dv2_s;
            4'd15:   ram_byte_s = (snap_q.light2 == LAMP_GREEN)  ? LED_ON : BYTE_ZERO;
            default: ram_byte_s = BYTE_ZERO;
        endcase
    end

    // Frame sequencing, snapshot capture and pending-frame bookkeeping
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        frame_start_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q || tick_s) begin
                    frame_start_s = 1'b1;
                    snap_d        = live_s;
                    state_d       = S_CMD_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD_DATA: begin
                if (xfer_s) state_d = S_CMD_ADDR;
                else        state_d = S_CMD_DATA;
            end
            S_CMD_ADDR: begin
                if (xfer_s) begin
                    state_d = S_DATA;
                    idx_d   = 4'd0;
                end else begin
                    state_d = S_CMD_ADDR;
                end
            end
            S_DATA: begin
                if (xfer_s && (idx_q == IDX_LAST)) begin
                    state_d = S_CMD_DISP;
                    idx_d   = 4'd0;
                end else if (xfer_s) begin
                    idx_d = idx_q + 4'd1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CMD_DISP: begin
                if (xfer_s) state_d = S_IDLE;
                else        state_d = S_CMD_DISP;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
        endcase

        // Starting a frame consumes every request seen so far
        if (frame_start_s) begin
            pending_d = 1'b0;
        end else if (change_s || tick_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Next output byte follows the next state, so outputs can be registered
    always_comb begin
        byte_data_d  = BYTE_ZERO;
        byte_valid_d = 1'b0;
        byte_last_d  = 1'b0;
        busy_d       = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_CMD_DATA: begin
                byte_data_d  = CMD_DATA_AUTO;
                byte_valid_d = 1'b1;
                byte_last_d  = 1'b1;
                busy_d       = 1'b1;
            end
            S_CMD_ADDR: begin
                byte_data_d  = CMD_ADDR0;
                byte_valid_d = 1'b1;
                busy_d       = 1'b1;
            end
            S_DATA: begin
                byte_data_d  = ram_byte_s;
                byte_valid_d = 1'b1;
                byte_last_d  = (idx_d == IDX_LAST);
                busy_d       = 1'b1;
            end
            S_CMD_DISP: begin
                byte_data_d  = CMD_DISP_ON | {5'b00000, BRIGHTNESS};
                byte_valid_d = 1'b1;
                byte_last_d  = 1'b1;
                busy_d       = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers; reset aborts any frame in flight
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 4'd0;
            snap_q       <= '0;
            pending_q    <= 1'b1;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            pending_q    <= pending_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            byte_last_q  <= byte_last_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_tm1638_frame_builder.sv
// Self-checking bench for tm1638_frame_builder: vector table of display
// contents, byte scoreboard, stall stability, mid-frame change, reset abort
// and periodic refresh.
module tb_tm1638_frame_builder;

    typedef struct {
        logic [3:0]  c1, d1, c2, d2;
        logic [1:0]  l1, l2;
        logic [31:0] seg;   // expected codes {chuc1, dv1, chuc2, dv2}
        logic [7:0]  led;   // expected LED k lit at bit k
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] c1 = 4'd0, d1 = 4'd0, c2 = 4'd0, d2 = 4'd0;
    logic [1:0] l1 = 2'd0, l2 = 2'd0;
    logic       ready = 1'b1;
    logic       r_ready = 1'b1;
    logic [7:0] byte_data, r_data;
    logic       byte_valid, byte_last, busy;
    logic       r_valid, r_last, r_busy;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   xfer_cnt = 0;
    int   main_starts = 0;
    int   cyc = 0;
    bit   stall_mode = 1'b0;
    bit   log_en = 1'b0;
    exp_t sb_q[$];
    int   r_starts[$];
    vec_t vecs[5];

    always #10 clk = ~clk;

    tm1638_frame_builder #(.BRIGHTNESS(3'd7), .REFRESH_CYCLES(0)) dut (
        .clk_50M(clk), .reset(reset),
        .light_chuc1(c1), .light_dv1(d1), .light_chuc2(c2), .light_dv2(d2),
        .light1(l1), .light2(l2),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(ready), .busy(busy)
    );

    tm1638_frame_builder #(.BRIGHTNESS(3'd7), .REFRESH_CYCLES(100)) dut_r100 (
        .clk_50M(clk), .reset(reset),
        .light_chuc1(c1), .light_dv1(d1), .light_chuc2(c2), .light_dv2(d2),
        .light1(l1), .light2(l2),
        .byte_data(r_data), .byte_valid(r_valid), .byte_last(r_last),
        .byte_ready(r_ready), .busy(r_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                input logic [3:0] d, input logic [1:0] x, input logic [1:0] y,
                                input logic [31:0] seg, input logic [7:0] led);
        vec_t v;
        v.c1 = a; v.d1 = b; v.c2 = c; v.d2 = d; v.l1 = x; v.l2 = y;
        v.seg = seg; v.led = led;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        c1 = v.c1; d1 = v.d1; c2 = v.c2; d2 = v.d2; l1 = v.l1; l2 = v.l2;
    endtask

    // Queue the 19 bytes a frame for these display contents must contain
    task automatic push_frame(input vec_t v);
        exp_t       e;
        logic [7:0] b;
        e.data = 8'h40; e.last = 1'b1; sb_q.push_back(e);
        e.data = 8'hC0; e.last = 1'b0; sb_q.push_back(e);
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) begin
                case (k / 2)
                    0:       b = v.seg[31:24];
                    1:       b = v.seg[23:16];
                    6:       b = v.seg[15:8];
                    7:       b = v.seg[7:0];
                    default: b = 8'h00;
                endcase
            end else begin
                b = v.led[k / 2] ? 8'h01 : 8'h00;
            end
            e.data = b; e.last = (k == 15); sb_q.push_back(e);
        end
        e.data = 8'h8F; e.last = 1'b1; sb_q.push_back(e);
    endtask

    task automatic wait_frame_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy) done = 1'b1;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_xfer(input int target);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (xfer_cnt >= target) done = 1'b1;
        end
        check("wait_xfer", {31'd0, done}, 32'd1);
    endtask

    // Cycle counter for refresh timing
    always @(posedge clk) cyc++;

    // Shifter model: accepts always, or randomly stalls when asked
    always begin
        @(posedge clk);
        #1;
        ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Scoreboard and hold-stable monitor on the main instance
    logic       prev_stall = 1'b0, prev_busy = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (busy && !prev_busy) main_starts++;
            if (prev_stall) begin
                check("hold_valid", {31'd0, byte_valid}, 32'd1);
                check("hold_data", {24'd0, byte_data}, {24'd0, prev_data});
                check("hold_last", {31'd0, byte_last}, {31'd0, prev_last});
            end
            if (byte_valid && ready) begin
                xfer_cnt++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte (t=%0t)", byte_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("byte_data", {24'd0, byte_data}, {24'd0, e.data});
                    check("byte_last", {31'd0, byte_last}, {31'd0, e.last});
                end
            end
            prev_stall = byte_valid && !ready;
            prev_data  = byte_data;
            prev_last  = byte_last;
        end else begin
            prev_stall = 1'b0;
        end
        prev_busy = busy;
    end

    // Frame-start log for the refresh instance
    logic r_prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!reset && r_busy && !r_prev_busy && log_en) r_starts.push_back(cyc);
        r_prev_busy = r_busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   base;
        int   starts0;
        vec_t vf;

        vecs[0] = mk(4'd2, 4'd5, 4'd0, 4'd3, 2'b10, 2'b00, 32'h5B6D3F4F, 8'h81);
        vecs[1] = mk(4'd1, 4'd9, 4'hC, 4'd8, 2'b01, 2'b11, 32'h066F407F, 8'h02);
        vecs[2] = mk(4'd4, 4'd6, 4'd7, 4'hF, 2'b00, 2'b01, 32'h667D0740, 8'h44);
        vecs[3] = mk(4'd0, 4'd0, 4'd9, 4'd9, 2'b11, 2'b10, 32'h3F3F6F6F, 8'h20);
        vecs[4] = mk(4'hB, 4'hE, 4'hD, 4'd1, 2'b10, 2'b10, 32'h40404006, 8'h21);

        // Reset values
        apply(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",  {24'd0, byte_data},  32'd0);
        check("rst_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_last",  {31'd0, byte_last},  32'd0);
        check("rst_busy",  {31'd0, busy},       32'd0);

        // First frame begins right after reset release
        push_frame(vecs[0]);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("first_valid", {31'd0, byte_valid}, 32'd1);
        check("first_byte",  {24'd0, byte_data},  32'h40);
        wait_frame_done("frame0");
        check("frame0_busy", {31'd0, busy}, 32'd0);
        repeat (60) @(negedge clk);
        check("no_refresh_frame", main_starts, 32'd1);

        // Table of display contents; odd entries run under random stalls
        for (int i = 1; i < 5; i++) begin
            stall_mode = (i % 2 == 1);
            apply(vecs[i]);
            push_frame(vecs[i]);
            wait_frame_done("vec");
            check("vec_frames", main_starts, i + 1);
        end
        stall_mode = 1'b0;
        repeat (5) @(negedge clk);

        // Two changes during one frame: frame keeps its snapshot, one follow-up
        starts0 = main_starts;
        apply(vecs[0]);
        push_frame(vecs[0]);
        base = xfer_cnt;
        wait_xfer(base + 8);
        d1 = 4'd4;
        wait_xfer(base + 12);
        d1 = 4'd3;
        vf = vecs[0];
        vf.d1 = 4'd3;
        vf.seg[23:16] = 8'h4F;
        push_frame(vf);
        wait_frame_done("follow");
        repeat (40) @(negedge clk);
        check("follow_frames", main_starts, starts0 + 2);
        check("follow_queue", sb_q.size(), 32'd0);

        // Reset in the middle of a frame
        apply(vecs[2]);
        push_frame(vecs[2]);
        base = xfer_cnt;
        wait_xfer(base + 10);
        @(posedge clk);
        #1 reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", {31'd0, byte_valid}, 32'd0);
        check("abort_busy",  {31'd0, busy},       32'd0);
        push_frame(vecs[2]);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("restart_byte", {24'd0, byte_data}, 32'h40);
        wait_frame_done("restart");

        // Periodic refresh with static inputs
        repeat (200) @(negedge clk);
        starts0 = main_starts;
        r_starts.delete();
        log_en = 1'b1;
        repeat (450) @(negedge clk);
        log_en = 1'b0;
        check("refresh_count_ge4", {31'd0, r_starts.size() >= 4}, 32'd1);
        for (int i = 1; i < r_starts.size(); i++) begin
            check("refresh_period", r_starts[i] - r_starts[i-1], 32'd100);
        end
        check("main_no_refresh", main_starts, starts0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tm1638_frame_builder.md
Name: tm1638_frame_builder

Overview:
- Sits between counter_for_traffic and the TM1638 serial shifter.
- Snapshots the countdown digits and the two light states, then encodes them into a complete TM1638 display frame.
- A frame is three STB-delimited command transactions, streamed one byte at a time over a valid/ready handshake.
- The shifter owns DIO/SCLK/STB; this block owns frame content, ordering and refresh policy.

Parameters:
- BRIGHTNESS, 3'd7, display-control pulse width field; sent as byte 8'h88 | BRIGHTNESS.
- REFRESH_CYCLES, 1_000_000, clk_50M cycles between forced refresh frames; 0 disables periodic refresh.

Ports:
- clk_50M  input  1  block clock
- reset  input  1  synchronous, active-high reset
- light_chuc1  input  4  road 1 tens digit, BCD
- light_dv1  input  4  road 1 units digit, BCD
- light_chuc2  input  4  road 2 tens digit, BCD
- light_dv2  input  4  road 2 units digit, BCD
- light1  input  2  road 1 lamp state: 00 green, 01 yellow, 10 red, 11 off
- light2  input  2  road 2 lamp state, same encoding
- byte_data  output  8  byte to the shifter
- byte_valid  output  1  byte_data is valid
- byte_last  output  1  last byte of the current transaction; shifter raises STB after sending it
- byte_ready  input  1  shifter accepts the byte
- busy  output  1  a frame is in progress

Behaviour:
- Clock and reset: one clock, clk_50M. Reset is synchronous and active-high.
- Reset values: byte_data=0, byte_valid=0, byte_last=0, busy=0. The refresh counter clears to 0 and the pending flag sets to 1.
  - Result: the first frame starts on the first cycle after reset deasserts.
  - Reset mid-frame aborts the frame immediately with no partial completion.
- Transfer rule: a byte moves on a cycle where byte_valid && byte_ready.
  - While valid and not ready, byte_data, byte_valid and byte_last hold stable.
  - The next byte appears on the cycle after a transfer, with valid high. Zero bubbles are allowed.
- Frame start: in IDLE, if pending or a refresh tick is set:
  - Latch all six inputs into the snapshot register.
  - Clear pending.
  - Go to S_CMD_DATA. byte_valid rises the next cycle.
- State sequence:
  - S_CMD_DATA: byte 8'h40, last=1.
  - S_CMD_ADDR: byte 8'hC0, last=0.
  - S_DATA: idx 0..15, byte = ram(idx); last=1 only at idx 15.
  - S_CMD_DISP: byte 8'h88|BRIGHTNESS, last=1.
  - After S_CMD_DISP, return to IDLE. busy=1 in every state except IDLE.
- Frame length: 19 bytes and 3 transactions.
- RAM map:
  - Even idx 2k is the 7-seg code for digit k: digit0=chuc1, digit1=dv1, digit6=chuc2, digit7=dv2, digits 2..5 = 8'h00.
  - Odd idx 2k+1 is LED k, value 8'h01 when lit, else 8'h00.
  - LED0/1/2 show road 1 red/yellow/green; LED5/6/7 show road 2 red/yellow/green; LED3/4 are off.
  - Lamp state 11 lights nothing.
- 7-seg codes (gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. BCD values above 9 encode as 8'h40 (dash).
- Change detection: each cycle, compare the live inputs with the snapshot. On any difference, set pending, including during a frame.
  - Multiple changes during one frame produce exactly one follow-up frame.
  - An in-flight frame always uses its start-time snapshot; it never tears.
- Refresh counter:
  - Counts every cycle. At REFRESH_CYCLES-1 it wraps to 0 and sets pending.
  - A refresh tick coinciding with a change yields one frame.
  - REFRESH_CYCLES=0 means the counter is held at 0 and never ticks.
- Backpressure: byte_ready may stay low indefinitely. There is no timeout.

Decomposition:
- Package tm1638_pkg holds:
  - Command constants CMD_DATA_AUTO=8'h40, CMD_ADDR0=8'hC0, CMD_DISP_ON=8'h88.
  - State enum.
  - Lamp encoding constants.
  - The seg7 digit-code function.
- One natural sub-module: bcd_to_seg7, a combinational BCD→segment encoder, instantiated 4 times on the snapshot.
- FSM, index counter, refresh counter and change detection stay in the top.

Test Plan:
- Reset release with byte_ready=1, inputs chuc1=2, dv1=5, chuc2=0, dv2=3, light1=10, light2=00.
  - Expected 19 consecutive bytes: 40(last), C0, 5B, 01, 6D, 00, 00, 00, 00, 00, 00, 00, 00, 00, 3F, 00, 4F, 01(last), 8F(last); then busy=0.
  - LED map: LED0 red for road 1, LED7 green for road 2.
- Random byte_ready stalls.
  - byte_data and byte_last hold stable while stalled.
  - Byte sequence is identical to the no-stall case.
- Change dv1 from 5→4 at byte 8, then 4→3 at byte 12.
  - Current frame still shows 6D.
  - Exactly one follow-up frame follows, with 4F at idx 2.
- Assert reset during byte 10 of a frame.
  - Next cycle byte_valid=0 and busy=0.
  - After release, a full frame restarts from 40.
- REFRESH_CYCLES=100, inputs static: a frame starts every 100 cycles. With REFRESH_CYCLES=0, no frame follows the post-reset frame.
- chuc2=4'hC and light2=11: idx 12 is 40, and LEDs 5/6/7 are all 00.
